// File: rtl/qbus_pmo_core.sv
// QBUS slave core for the PMo FPGA: console switch/display register at 17777570.
// Bus lines arrive through inverting transceivers, so every R*/T*/ZDAL signal is true-sense.
module qbus_pmo_core #(
  parameter logic [12:0] CSR_ADDR   = 13'o17570,
  parameter logic [15:0] SWITCH_VAL = 16'o177777,
  parameter int unsigned RPLY_DELAY = 2
) (
  input  logic        qclk,
  input  logic        reset,
  output logic        led_d8,
  output logic        led_d9,
  output logic        led_d10,
  output logic        led_d11,
  output logic        led_c12,
  output logic        led_d12,
  output logic        tp_b30,
  output logic        DALbe_L,
  output logic        DALtx,
  output logic        DALst,
  inout  wire  [21:0] ZDAL,
  inout  wire         ZBS7,
  inout  wire         ZWTBT,
  input  logic        RSYNC,
  input  logic        RDIN,
  input  logic        RDOUT,
  input  logic        RRPLY,
  input  logic        RREF,
  input  logic        RIRQ4,
  input  logic        RIRQ5,
  input  logic        RIRQ6,
  input  logic        RIRQ7,
  input  logic        RDMR,
  input  logic        RSACK,
  input  logic        RINIT,
  input  logic        RIAKI,
  input  logic        RDMGI,
  input  logic        RDCOK,
  input  logic        RPOK,
  output logic        TSYNC,
  output logic        TDIN,
  output logic        TDOUT,
  output logic        TRPLY,
  output logic        TREF,
  output logic        TIRQ4,
  output logic        TIRQ5,
  output logic        TIRQ6,
  output logic        TIRQ7,
  output logic        TDMR,
  output logic        TSACK,
  output logic        TIAKO,
  output logic        TDMGO
);

  typedef enum logic [2:0] {
    IDLE, SEL, RD_DRV, RD_STB, RD_EN, RD_RPLY, WR_RPLY, WAIT_END
  } state_t;

  localparam logic [3:0] DLY_LAST = 4'(RPLY_DELAY - 1);

  state_t      state;
  logic [1:0]  sync_ff, din_ff, dout_ff, init_ff;
  logic [15:0] dal_p1, dal_al;
  logic [1:0]  bs7_ff, wtbt_ff;
  logic        sync_prev;
  logic        s_sync, s_din, s_dout, s_init;
  logic        sync_rise;
  logic        addr_lsb;
  logic [15:0] display;
  logic [3:0]  dly_cnt;
  logic        trply, dal_be_l, dal_tx, dal_st;
  logic        unused_inputs;

  assign s_sync    = sync_ff[1];
  assign s_din     = din_ff[1];
  assign s_dout    = dout_ff[1];
  assign s_init    = init_ff[1];
  assign sync_rise = s_sync && !sync_prev;

  // Bus samples go through the same two stages as the strobes so they line up.
  always_ff @(posedge qclk or posedge reset) begin
    if (reset) begin
      sync_ff   <= '0;
      din_ff    <= '0;
      dout_ff   <= '0;
      init_ff   <= '0;
      dal_p1    <= '0;
      dal_al    <= '0;
      bs7_ff    <= '0;
      wtbt_ff   <= '0;
      sync_prev <= 1'b0;
    end else begin
      sync_ff   <= {sync_ff[0], RSYNC};
      din_ff    <= {din_ff[0], RDIN};
      dout_ff   <= {dout_ff[0], RDOUT};
      init_ff   <= {init_ff[0], RINIT};
      dal_p1    <= ZDAL[15:0];
      dal_al    <= dal_p1;
      bs7_ff    <= {bs7_ff[0], ZBS7};
      wtbt_ff   <= {wtbt_ff[0], ZWTBT};
      sync_prev <= s_sync;
    end
  end

  always_ff @(posedge qclk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      display  <= '0;
      addr_lsb <= 1'b0;
      dly_cnt  <= '0;
      trply    <= 1'b0;
      dal_be_l <= 1'b1;
      dal_tx   <= 1'b0;
      dal_st   <= 1'b0;
    end else if (s_init) begin
      state    <= IDLE;
      display  <= '0;
      dly_cnt  <= '0;
      trply    <= 1'b0;
      dal_be_l <= 1'b1;
      dal_tx   <= 1'b0;
      dal_st   <= 1'b0;
    end else begin
      dal_st <= 1'b0;
      if (state != IDLE && !s_sync) begin
        // Abort: drop enables now, direction follows a cycle later from IDLE.
        state    <= IDLE;
        trply    <= 1'b0;
        dal_be_l <= 1'b1;
      end else begin
        case (state)
          IDLE: begin
            trply    <= 1'b0;
            dal_be_l <= 1'b1;
            dal_tx   <= 1'b0;
            if (sync_rise) begin
              addr_lsb <= dal_al[0];
              state    <= (bs7_ff[1] && dal_al[12:0] == CSR_ADDR) ? SEL : WAIT_END;
            end
          end
          SEL: begin
            trply    <= 1'b0;
            dal_be_l <= 1'b1;
            dal_tx   <= 1'b0;
            if (s_din) begin
              dal_tx <= 1'b1;
              state  <= RD_DRV;
            end else if (s_dout) begin
              if (!wtbt_ff[1])
                display <= dal_al;
              else if (addr_lsb)
                display[15:8] <= dal_al[15:8];
              else
                display[7:0] <= dal_al[7:0];
              trply <= 1'b1;
              state <= WR_RPLY;
            end
          end
          RD_DRV: begin
            dal_st <= 1'b1;
            state  <= RD_STB;
          end
          RD_STB: begin
            dal_be_l <= 1'b0;
            dly_cnt  <= '0;
            state    <= RD_EN;
          end
          RD_EN: begin
            if (dly_cnt == DLY_LAST) begin
              trply <= 1'b1;
              state <= RD_RPLY;
            end else begin
              dly_cnt <= dly_cnt + 4'd1;
            end
          end
          RD_RPLY: begin
            if (!s_din) begin
              trply    <= 1'b0;
              dal_be_l <= 1'b1;
              state    <= SEL;
            end
          end
          WR_RPLY: begin
            if (!s_dout) begin
              trply <= 1'b0;
              state <= SEL;
            end
          end
          WAIT_END: state <= WAIT_END;
          default:  state <= IDLE;
        endcase
      end
    end
  end

  assign ZDAL    = dal_tx ? {6'b0, SWITCH_VAL} : 'z;
  assign DALbe_L = dal_be_l;
  assign DALtx   = dal_tx;
  assign DALst   = dal_st;
  assign TRPLY   = trply;
  assign tp_b30  = trply;

  assign led_d8  = display[0];
  assign led_d9  = display[1];
  assign led_d10 = display[2];
  assign led_d11 = display[3];
  assign led_c12 = display[4];
  assign led_d12 = display[5];

  assign TSYNC = 1'b0;
  assign TDIN  = 1'b0;
  assign TDOUT = 1'b0;
  assign TREF  = 1'b0;
  assign TIRQ4 = 1'b0;
  assign TIRQ5 = 1'b0;
  assign TIRQ6 = 1'b0;
  assign TIRQ7 = 1'b0;
  assign TDMR  = 1'b0;
  assign TSACK = 1'b0;
  assign TIAKO = RIAKI;
  assign TDMGO = RDMGI;

  assign unused_inputs = ^{RRPLY, RREF, RIRQ4, RIRQ5, RIRQ6, RIRQ7, RDMR, RSACK,
                           RDCOK, RPOK, ZDAL[21:16]};

endmodule

// File: tb/tb_qbus_pmo_core.sv
// Directed bench for qbus_pmo_core: bus master model with a scoreboard of expected replies.
`timescale 1ns/1ps
module tb_qbus_pmo_core;

  localparam logic [15:0] SW = 16'o177777;

  logic qclk = 1'b0;
  logic reset;
  logic led_d8, led_d9, led_d10, led_d11, led_c12, led_d12, tp_b30;
  logic DALbe_L, DALtx, DALst;
  logic RSYNC, RDIN, RDOUT, RINIT, RIAKI, RDMGI;
  logic TSYNC, TDIN, TDOUT, TRPLY, TREF, TIRQ4, TIRQ5, TIRQ6, TIRQ7;
  logic TDMR, TSACK, TIAKO, TDMGO;

  logic [21:0] tb_dal;
  logic        tb_dal_oe, tb_bs7, tb_wtbt;
  wire  [21:0] zdal;
  wire         zbs7, zwtbt;
  assign zdal  = tb_dal_oe ? tb_dal : 'z;
  assign zbs7  = tb_bs7;
  assign zwtbt = tb_wtbt;

  int passed = 0;
  int total  = 0;
  int order_viol = 0;
  logic [15:0] exp_q[$];

  always #25 qclk = ~qclk;

  qbus_pmo_core #(
    .CSR_ADDR(13'o17570),
    .SWITCH_VAL(16'o177777),
    .RPLY_DELAY(2)
  ) dut (
    .qclk(qclk), .reset(reset),
    .led_d8(led_d8), .led_d9(led_d9), .led_d10(led_d10), .led_d11(led_d11),
    .led_c12(led_c12), .led_d12(led_d12), .tp_b30(tp_b30),
    .DALbe_L(DALbe_L), .DALtx(DALtx), .DALst(DALst),
    .ZDAL(zdal), .ZBS7(zbs7), .ZWTBT(zwtbt),
    .RSYNC(RSYNC), .RDIN(RDIN), .RDOUT(RDOUT), .RRPLY(1'b0), .RREF(1'b0),
    .RIRQ4(1'b0), .RIRQ5(1'b0), .RIRQ6(1'b0), .RIRQ7(1'b0),
    .RDMR(1'b0), .RSACK(1'b0), .RINIT(RINIT), .RIAKI(RIAKI), .RDMGI(RDMGI),
    .RDCOK(1'b1), .RPOK(1'b1),
    .TSYNC(TSYNC), .TDIN(TDIN), .TDOUT(TDOUT), .TRPLY(TRPLY), .TREF(TREF),
    .TIRQ4(TIRQ4), .TIRQ5(TIRQ5), .TIRQ6(TIRQ6), .TIRQ7(TIRQ7),
    .TDMR(TDMR), .TSACK(TSACK), .TIAKO(TIAKO), .TDMGO(TDMGO)
  );

  always @(negedge qclk)
    if (!DALbe_L && !DALtx) order_viol++;

  function automatic logic [5:0] leds();
    return {led_d12, led_c12, led_d11, led_d10, led_d9, led_d8};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0o expected %0o", tag, obs, exp);
  endtask

  task automatic wait_rply(input logic level, input int limit, output int n);
    n = 0;
    while (TRPLY !== level && n < limit) begin
      @(negedge qclk);
      n++;
    end
  endtask

  task automatic start_cycle(input logic [21:0] addr, input logic bs7);
    @(negedge qclk);
    tb_dal = addr; tb_dal_oe = 1'b1; tb_bs7 = bs7;
    @(negedge qclk);
    RSYNC = 1'b1;
    repeat (3) @(negedge qclk);
    tb_dal_oe = 1'b0; tb_bs7 = 1'b0;
  endtask

  task automatic end_cycle();
    RSYNC = 1'b0;
    repeat (4) @(negedge qclk);
    check("idle_after_sync", {TRPLY, DALbe_L, DALtx}, 3'b010);
  endtask

  task automatic read_phase();
    int n;
    logic [15:0] exp;
    exp_q.push_back(SW);
    RDIN = 1'b1;
    wait_rply(1'b1, 12, n);
    check("rd_rply", TRPLY, 1'b1);
    check("rd_latency_le8", n <= 8, 1'b1);
    check("rd_drivers", {DALtx, DALbe_L, tp_b30}, 3'b101);
    exp = exp_q.pop_front();
    check("rd_data", zdal[15:0], exp);
    RDIN = 1'b0;
    wait_rply(1'b0, 6, n);
    check("rd_release_le3", n <= 3 && TRPLY === 1'b0, 1'b1);
    check("rd_be_off", DALbe_L, 1'b1);
    @(negedge qclk);
    check("rd_tx_off", DALtx, 1'b0);
  endtask

  task automatic write_phase(input logic [15:0] data, input logic wtbt, input logic [15:0] exp_disp);
    int n;
    logic [15:0] exp;
    @(negedge qclk);
    tb_dal = {6'b0, data}; tb_dal_oe = 1'b1; tb_wtbt = wtbt;
    @(negedge qclk);
    RDOUT = 1'b1;
    exp_q.push_back(exp_disp);
    wait_rply(1'b1, 8, n);
    check("wr_rply", TRPLY, 1'b1);
    check("wr_latency_le4", n <= 4, 1'b1);
    exp = exp_q.pop_front();
    check("wr_display", dut.display, exp);
    check("wr_leds", leds(), exp[5:0]);
    RDOUT = 1'b0;
    wait_rply(1'b0, 6, n);
    check("wr_release_le3", n <= 3 && TRPLY === 1'b0, 1'b1);
    tb_dal_oe = 1'b0; tb_wtbt = 1'b0;
  endtask

  task automatic no_response(input string tag, input logic [21:0] addr, input logic bs7);
    logic bad;
    start_cycle(addr, bs7);
    RDIN = 1'b1;
    bad = 1'b0;
    repeat (20) begin
      @(negedge qclk);
      if (TRPLY !== 1'b0 || DALtx !== 1'b0 || DALbe_L !== 1'b1) bad = 1'b1;
    end
    check(tag, bad, 1'b0);
    RDIN = 1'b0;
    end_cycle();
  endtask

  initial begin
    int n;
    reset = 1'b1; RSYNC = 0; RDIN = 0; RDOUT = 0; RINIT = 0; RIAKI = 0; RDMGI = 0;
    tb_dal = '0; tb_dal_oe = 0; tb_bs7 = 0; tb_wtbt = 0;
    repeat (3) @(negedge qclk);
    check("reset_drivers", {TRPLY, DALbe_L, DALtx, DALst}, 4'b0100);
    check("reset_leds", leds(), 6'o00);
    check("const_outputs", {TSYNC, TDIN, TDOUT, TREF, TIRQ4, TIRQ5, TIRQ6, TIRQ7, TDMR, TSACK}, 10'b0);
    reset = 1'b0;
    repeat (3) @(negedge qclk);

    start_cycle(22'o17777570, 1'b1); read_phase(); end_cycle();
    start_cycle(22'o17777570, 1'b1); write_phase(16'o054321, 1'b0, 16'o054321); end_cycle();
    start_cycle(22'o17777570, 1'b1); read_phase(); end_cycle();
    // DATIO: read then write inside one SYNC
    start_cycle(22'o17777570, 1'b1); read_phase();
    write_phase(16'o054545, 1'b0, 16'o054545); end_cycle();
    start_cycle(22'o17777570, 1'b1); write_phase(16'h00AA, 1'b1, 16'h59AA); end_cycle();

    no_response("noresp_572", 22'o17777572, 1'b1);
    no_response("noresp_nobs7", 22'o00017570, 1'b0);

    RIAKI = 1'b1; #1 check("iak_pass", TIAKO, 1'b1);
    RIAKI = 1'b0; #1 check("iak_drop", TIAKO, 1'b0);
    RDMGI = 1'b1; #1 check("dmg_pass", TDMGO, 1'b1);
    RDMGI = 1'b0; #1 check("dmg_drop", TDMGO, 1'b0);

    start_cycle(22'o17777570, 1'b1);
    RDIN = 1'b1;
    wait_rply(1'b1, 12, n);
    check("rst_mid_rply", TRPLY, 1'b1);
    #5 reset = 1'b1;
    #1 check("rst_async", {TRPLY, DALbe_L}, 2'b01);
    check("rst_display", dut.display, 16'h0000);
    RDIN = 1'b0; RSYNC = 1'b0;
    repeat (3) @(negedge qclk);
    reset = 1'b0;
    repeat (3) @(negedge qclk);
    start_cycle(22'o17777570, 1'b1); read_phase(); end_cycle();

    start_cycle(22'o17777570, 1'b1); write_phase(16'o054321, 1'b0, 16'o054321); end_cycle();
    start_cycle(22'o17777570, 1'b1);
    RDIN = 1'b1;
    wait_rply(1'b1, 12, n);
    check("init_mid_rply", TRPLY, 1'b1);
    RINIT = 1'b1;
    repeat (4) @(negedge qclk);
    check("init_drivers", {TRPLY, DALbe_L}, 2'b01);
    check("init_display", dut.display, 16'h0000);
    check("init_leds", leds(), 6'o00);
    RDIN = 1'b0; RSYNC = 1'b0;
    repeat (3) @(negedge qclk);
    RINIT = 1'b0;
    repeat (4) @(negedge qclk);
    start_cycle(22'o17777570, 1'b1); read_phase(); end_cycle();

    check("drive_order", order_viol, 0);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/qbus_pmo_core.md
Name: qbus_pmo_core

Overview:
- QBUS slave core for the PMo FPGA. Connects to the bus through external inverting Am2908-style transceivers, so all R*/T*/ZDAL signals are active-high true-sense.
- Implements a console switch/display register in the I/O page at 17777570.
  - Reads return the switch value.
  - Writes load a display register, which is shown on LEDs.
- Passes interrupt and DMA grants through, and never becomes bus master.

Parameters:
- CSR_ADDR, 13'o17570, I/O-page offset decoded when BS7 is asserted.
- SWITCH_VAL, 16'o177777, value returned on read.
- RPLY_DELAY, 2, qclk cycles between DALbe_L assertion and TRPLY assertion.

Ports:
- qclk, input, 1, 20 MHz system clock; all logic is on its rising edge.
- reset, input, 1, asynchronous, active-high.
- led_d8, led_d9, led_d10, led_d11, led_c12, led_d12, output, 1 each, display[0..5] in that order.
- tp_b30, output, 1, test point; mirrors TRPLY.
- DALbe_L, output, 1, low enables transceiver bus drivers.
- DALtx, output, 1, 1 = FPGA-to-bus direction.
- DALst, output, 1, one-cycle strobe loading the transceiver output latches.
- ZDAL, inout, 22, data/address path (tristate).
- ZBS7, ZWTBT, inout, 1 each; input only, never driven (high-Z).
- RSYNC, RDIN, RDOUT, RRPLY, RREF, RIRQ4..RIRQ7, RDMR, RSACK, RINIT, RIAKI, RDMGI, RDCOK, RPOK, input, 1 each, received bus lines.
- TSYNC, TDIN, TDOUT, TRPLY, TREF, TIRQ4..TIRQ7, TDMR, TSACK, TIAKO, TDMGO, output, 1 each, bus drivers.

Behaviour:
- Reset (async) or synced RINIT: state IDLE, display=0, TRPLY=0, DALbe_L=1, DALtx=0, DALst=0, ZDAL high-Z.
- Constant outputs: TSYNC, TDIN, TDOUT, TREF, TIRQ4-7, TDMR, TSACK are 0.
- Grant pass-through: TIAKO=RIAKI and TDMGO=RDMGI, combinational.
- Synchronisers: RSYNC, RDIN, RDOUT, RINIT use two flops each.
- Aligned samples: ZDAL, ZBS7, ZWTBT are registered through a matching 2-deep pipeline so samples align with the synced strobes.
- States: IDLE, SEL, RD_DRV, RD_STB, RD_EN, RD_RPLY, WR_RPLY, WAIT_END.
- IDLE:
  - On synced-SYNC rising edge, latch the aligned address.
  - Match = BS7 && addr[12:0]==CSR_ADDR.
  - Match -> SEL; else -> WAIT_END (no response).
- SEL:
  - Synced DIN -> RD_DRV.
  - Synced DOUT -> write display: word write, or a byte lane chosen by addr[0] if WTBT is asserted in the data phase. Then -> WR_RPLY.
  - SYNC negated -> IDLE.
- RD_DRV: DALtx=1; ZDAL[15:0]=SWITCH_VAL, ZDAL[21:16]=0 -> RD_STB.
- RD_STB: DALst=1 for one cycle -> RD_EN.
- RD_EN: DALbe_L=0; after RPLY_DELAY cycles -> RD_RPLY.
- RD_RPLY:
  - TRPLY=1 and data held until synced DIN negates.
  - Then TRPLY=0, DALbe_L=1, next cycle DALtx=0 and ZDAL high-Z -> SEL. This permits DATIO write phase.
- WR_RPLY: TRPLY=1 until synced DOUT negates, then TRPLY=0 -> SEL.
- WAIT_END: return to IDLE on synced SYNC negation.
- SYNC negation in any state -> IDLE, with all drivers released within 2 cycles.
- Latency: DIN assertion to TRPLY assertion ≤ 8 qclk (400 ns). DOUT to TRPLY ≤ 4 qclk.
- Reply release: TRPLY drops ≤ 3 qclk after DIN/DOUT negation.
- Drive ordering: DALbe_L is never low while DALtx=0. ZDAL is only driven when DALtx=1.

Test Plan:
- Read DATI 17777570 (address with BS7, SYNC, then DIN):
  - RPLY within 400 ns; bus data 177777.
  - After DIN drops, RPLY releases and DALbe_L returns to 1.
- Write DATO 054321 to 17777570:
  - RPLY asserted; display = 054321; LEDs = 6'o21.
  - A subsequent read still returns 177777.
- DATIO at 17777570: read returns 177777, then write 054545 gets RPLY; display = 054545.
- No response expected, with RPLY held 0 for 1 µs and ZDAL never driven, for each of:
  - Read 17777572.
  - Read address 17570 without BS7.
- Grants: RIAKI=1 -> TIAKO=1; RDMGI=1 -> TDMGO=1; both follow deassertion.
- Reset asserted mid-read at RD_RPLY:
  - TRPLY=0, DALbe_L=1, display=0 immediately.
  - After reset, the next read completes normally.
- RINIT pulse gives the same result as reset.
